// File: rtl/colour_bbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : colour_bbox_pkg
//  Description : Shared types and constants for the colour bounding-box
//                detector. It defines the register field offsets, the VIP
//                packet type, the overlay mode encodings, the mask palette,
//                the coordinate and counter widths, the FSM state type and
//                the latched box record.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package colour_bbox_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 20;

  // Register field offsets (low two bits of s_address)
  localparam logic [1:0] FLD_MIN = 2'd0;
  localparam logic [1:0] FLD_MAX = 2'd1;
  localparam logic [1:0] FLD_BX  = 2'd2;
  localparam logic [1:0] FLD_BY  = 2'd3;

  localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_MASK     = 2'd1;
  localparam logic [1:0] MODE_BOX      = 2'd2;
  localparam logic [1:0] MODE_PASS_ALT = 2'd3;

  localparam logic [23:0] PAL_WHITE = 24'hFFFFFF;
  // Index 0 is the lowest slice: red, green, blue, yellow.
  localparam logic [3:0][23:0] PALETTE = {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VIDEO = 2'd1,
    ST_OTHER = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } box_t;

  // Mask colour for a class index; classes 4 and above are white.
  function automatic logic [23:0] palette(input int unsigned idx);
    logic [1:0] sel;
    sel = idx[1:0];
    if (idx < 4) return PALETTE[sel];
    return PAL_WHITE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/colour_bbox_acc.sv
`default_nettype none
// ============================================================================
//  Module      : colour_bbox_acc
//  Description : One colour class. Compares the pixel against an inclusive
//                RGB window, accumulates the bounding box and the match count
//                of the frame, and latches the box on the frame's eop.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                pix_data       - current pixel RGB
//                thr_min/max    - RGB window, inclusive
//                pix_en         - pixel is inside the active area
//                latch          - last pixel of a video frame
//                x, y           - coordinates of the current pixel
//                match          - combinational window hit for pix_data
//                box            - latched box of the last completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module colour_bbox_acc
  import colour_bbox_pkg::*;
#(
  parameter int MIN_COUNT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [23:0]        pix_data,
  input  logic [23:0]        thr_min,
  input  logic [23:0]        thr_max,
  input  logic               pix_en,
  input  logic               latch,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               match,
  output box_t               box
);

  logic               seen_q, seen_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  box_t               box_q, box_d;

  always_comb begin
    match = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      if (pix_data[8*ch +: 8] < thr_min[8*ch +: 8] ||
          pix_data[8*ch +: 8] > thr_max[8*ch +: 8]) begin
        match = 1'b0;
      end
    end
  end

  always_comb begin
    seen_d = seen_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    box_d  = box_q;
    if (pix_en && match) begin
      if (!seen_q) begin
        seen_d = 1'b1;
        xmin_d = x;
        xmax_d = x;
        ymin_d = y;
        ymax_d = y;
      end else begin
        if (x < xmin_q) xmin_d = x;
        if (x > xmax_q) xmax_d = x;
        if (y < ymin_q) ymin_d = y;
        if (y > ymax_q) ymax_d = y;
      end
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
    // The latched box must include the eop pixel, so it is taken from the
    // updated values before the accumulator is cleared for the next frame.
    if (latch) begin
      box_d.valid = (cnt_d >= CNT_W'(MIN_COUNT));
      box_d.xmin  = xmin_d;
      box_d.xmax  = xmax_d;
      box_d.ymin  = ymin_d;
      box_d.ymax  = ymax_d;
      seen_d      = 1'b0;
      xmin_d      = '0;
      xmax_d      = '0;
      ymin_d      = '0;
      ymax_d      = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
      box_q  <= '0;
    end else begin
      seen_q <= seen_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q  <= cnt_d;
      box_q  <= box_d;
    end
  end

  assign box = box_q;

endmodule
`default_nettype wire

// File: rtl/colour_bbox_detector.sv
`default_nettype none
// ============================================================================
//  Module      : colour_bbox_detector
//  Description : Inline Avalon-ST video stage. It classifies pixels against
//                NUM_COLOURS RGB windows, latches one bounding box per colour
//                per frame, publishes the boxes over Avalon-MM and can
//                overlay a colour mask or the box outlines on the video.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                sink_*                  - Avalon-ST video input
//                source_*                - Avalon-ST video output (registered)
//                mode                    - 0/3 pass, 1 mask, 2 box outline
//                s_address/read/write/
//                s_writedata/s_readdata  - register port, read latency 1
//  Revision    : 1.0 - initial release
// ============================================================================
module colour_bbox_detector
  import colour_bbox_pkg::*;
#(
  parameter int  NUM_COLOURS = 4,
  parameter int  IMAGE_W     = 640,
  parameter int  IMAGE_H     = 480,
  parameter int  MIN_COUNT   = 16,
  localparam int AW          = $clog2(NUM_COLOURS) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [23:0]   sink_data,
  input  logic          sink_valid,
  output logic          sink_ready,
  input  logic          sink_sop,
  input  logic          sink_eop,
  output logic [23:0]   source_data,
  output logic          source_valid,
  input  logic          source_ready,
  output logic          source_sop,
  output logic          source_eop,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] s_address,
  input  logic          s_read,
  input  logic          s_write,
  input  logic [31:0]   s_writedata,
  output logic [31:0]   s_readdata
);

  localparam int CIW = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               src_valid_q, src_valid_d, src_sop_q, src_sop_d, src_eop_q, src_eop_d;
  logic [23:0]        src_data_q, src_data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [23:0]        thr_min_q [NUM_COLOURS];
  logic [23:0]        thr_min_d [NUM_COLOURS];
  logic [23:0]        thr_max_q [NUM_COLOURS];
  logic [23:0]        thr_max_d [NUM_COLOURS];

  logic                   w_xfer, w_fwd, w_pix, w_latch, w_stat_en;
  logic                   w_any, w_on_box;
  logic [23:0]            w_mask_col, w_out_data;
  logic [NUM_COLOURS-1:0] w_match;
  box_t                   w_box [NUM_COLOURS];
  logic [CIW-1:0]         w_col;

  assign sink_ready = source_ready | ~src_valid_q;
  assign w_xfer     = sink_valid & sink_ready;
  assign w_stat_en  = w_pix & (y_q < COORD_W'(IMAGE_H));

  generate
    if (NUM_COLOURS > 1) begin : g_col_multi
      assign w_col = s_address[AW-1:2];
    end else begin : g_col_single
      assign w_col = '0;
    end
  endgenerate

  generate
    for (genvar g = 0; g < NUM_COLOURS; g++) begin : g_acc
      colour_bbox_acc #(
        .MIN_COUNT(MIN_COUNT)
      ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .pix_data(sink_data),
        .thr_min (thr_min_q[g]),
        .thr_max (thr_max_q[g]),
        .pix_en  (w_stat_en),
        .latch   (w_latch),
        .x       (x_q),
        .y       (y_q),
        .match   (w_match[g]),
        .box     (w_box[g])
      );
    end
  endgenerate

  // Packet FSM and raster coordinates
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_fwd   = 1'b0;
    w_pix   = 1'b0;
    w_latch = 1'b0;
    if (w_xfer) begin
      case (state_q)
        ST_IDLE: begin
          // Non-sop beats here are consumed and dropped.
          if (sink_sop) begin
            w_fwd = 1'b1;
            if (sink_eop) begin
              state_d = ST_IDLE;
            end else if (sink_data[3:0] == VIP_PKT_VIDEO) begin
              state_d = ST_VIDEO;
              x_d     = '0;
              y_d     = '0;
            end else begin
              state_d = ST_OTHER;
            end
          end
        end
        ST_VIDEO: begin
          w_fwd = 1'b1;
          w_pix = 1'b1;
          if (x_q == COORD_W'(IMAGE_W - 1)) begin
            x_d = '0;
            if (y_q != COORD_W'(IMAGE_H)) y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (sink_eop) begin
            w_latch = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_OTHER: begin
          w_fwd = 1'b1;
          if (sink_eop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Overlay: lowest matching class wins the mask colour.
  always_comb begin
    w_any      = 1'b0;
    w_on_box   = 1'b0;
    w_mask_col = PAL_WHITE;
    w_out_data = sink_data;
    for (int c = NUM_COLOURS - 1; c >= 0; c--) begin
      if (w_match[c]) begin
        w_any      = 1'b1;
        w_mask_col = palette(c);
      end
    end
    for (int c = 0; c < NUM_COLOURS; c++) begin
      if (w_box[c].valid &&
          (((x_q == w_box[c].xmin || x_q == w_box[c].xmax) &&
            y_q >= w_box[c].ymin && y_q <= w_box[c].ymax) ||
           ((y_q == w_box[c].ymin || y_q == w_box[c].ymax) &&
            x_q >= w_box[c].xmin && x_q <= w_box[c].xmax))) begin
        w_on_box = 1'b1;
      end
    end
    if (w_pix) begin
      if (mode == MODE_MASK && w_any) begin
        w_out_data = w_mask_col;
      end else if (mode == MODE_BOX && w_on_box) begin
        w_out_data = PAL_WHITE;
      end
    end
  end

  // Output register: loads whenever the downstream slot is free.
  always_comb begin
    src_valid_d = src_valid_q;
    src_data_d  = src_data_q;
    src_sop_d   = src_sop_q;
    src_eop_d   = src_eop_q;
    if (sink_ready) begin
      src_valid_d = w_fwd;
      if (w_fwd) begin
        src_data_d = w_out_data;
        src_sop_d  = sink_sop;
        src_eop_d  = sink_eop;
      end
    end
  end

  // Register port. Reads sample current state, so a read colliding with a
  // write or a box latch returns the old value.
  always_comb begin
    for (int c = 0; c < NUM_COLOURS; c++) begin
      thr_min_d[c] = thr_min_q[c];
      thr_max_d[c] = thr_max_q[c];
    end
    if (s_write) begin
      case (s_address[1:0])
        FLD_MIN: thr_min_d[w_col] = s_writedata[23:0];
        FLD_MAX: thr_max_d[w_col] = s_writedata[23:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      case (s_address[1:0])
        FLD_MIN: rdata_d = {8'h00, thr_min_q[w_col]};
        FLD_MAX: rdata_d = {8'h00, thr_max_q[w_col]};
        FLD_BX:  rdata_d = {w_box[w_col].valid, 4'b0, w_box[w_col].xmax, 5'b0, w_box[w_col].xmin};
        default: rdata_d = {w_box[w_col].valid, 4'b0, w_box[w_col].ymax, 5'b0, w_box[w_col].ymin};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      src_valid_q <= 1'b0;
      src_data_q  <= '0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      rdata_q     <= '0;
      for (int c = 0; c < NUM_COLOURS; c++) begin
        thr_min_q[c] <= '0;
        thr_max_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      src_valid_q <= src_valid_d;
      src_data_q  <= src_data_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      rdata_q     <= rdata_d;
      for (int c = 0; c < NUM_COLOURS; c++) begin
        thr_min_q[c] <= thr_min_d[c];
        thr_max_q[c] <= thr_max_d[c];
      end
    end
  end

  assign source_valid = src_valid_q;
  assign source_data  = src_data_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign s_readdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_colour_bbox_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_colour_bbox_detector
//  Description : Self-checking bench for colour_bbox_detector with an 8x4
//                image. A frame-level reference model predicts every output
//                beat and every box register from the pixel list.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_colour_bbox_detector;

  localparam int NC = 4;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int MC = 2;
  localparam logic [23:0] HDR_VID = 24'h5A5A50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic        sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  s_address = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;

  colour_bbox_detector #(
    .NUM_COLOURS(NC), .IMAGE_W(W), .IMAGE_H(H), .MIN_COUNT(MC)
  ) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .mode(mode), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int bp    = 0;   // 0 always ready, 1 toggle, 2 random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] m_min [NC];
  logic [23:0] m_max [NC];
  logic        m_valid [NC];
  int          m_xmin [NC], m_xmax [NC], m_ymin [NC], m_ymax [NC];
  logic [25:0] exp_q [$];
  logic [23:0] fpix [64];

  function automatic logic m_match(int c, logic [23:0] p);
    for (int k = 0; k < 3; k++) begin
      if (p[8*k +: 8] < m_min[c][8*k +: 8] || p[8*k +: 8] > m_max[c][8*k +: 8]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [23:0] m_pal(int c);
    case (c)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      3: return 24'hFFFF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [31:0] m_reg(int c, int f);
    case (f)
      0: return {8'h00, m_min[c]};
      1: return {8'h00, m_max[c]};
      2: return {m_valid[c], 4'b0, 11'(m_xmax[c]), 5'b0, 11'(m_xmin[c])};
      default: return {m_valid[c], 4'b0, 11'(m_ymax[c]), 5'b0, 11'(m_ymin[c])};
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NC; c++) begin
      m_min[c] = '0; m_max[c] = '0; m_valid[c] = 1'b0;
      m_xmin[c] = 0; m_xmax[c] = 0; m_ymin[c] = 0; m_ymax[c] = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop);
    logic ok;
    int   t;
    t = 0;
    sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = sink_ready;
      @(posedge clk);
      t++;
    end while (!ok && t < 200);
    #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    if (!ok) check("send_timeout", {31'b0, ok}, 32'd1);
  endtask

  // Video frame of n pixels from fpix; model updates boxes only on eop.
  task automatic send_frame(input int n, input logic [1:0] md, input logic with_eop);
    logic [23:0] o;
    int x, y, cnt;
    mode = md;
    exp_q.push_back({1'b1, 1'b0, HDR_VID});
    for (int i = 0; i < n; i++) begin
      x = i % W;
      y = (i / W > H) ? H : i / W;
      o = fpix[i];
      if (md == 2'd1) begin
        for (int c = NC - 1; c >= 0; c--) if (m_match(c, fpix[i])) o = m_pal(c);
      end else if (md == 2'd2) begin
        for (int c = 0; c < NC; c++) begin
          if (m_valid[c] &&
              (((x == m_xmin[c] || x == m_xmax[c]) && y >= m_ymin[c] && y <= m_ymax[c]) ||
               ((y == m_ymin[c] || y == m_ymax[c]) && x >= m_xmin[c] && x <= m_xmax[c])))
            o = 24'hFFFFFF;
        end
      end
      exp_q.push_back({1'b0, (with_eop && i == n - 1), o});
    end
    send_beat(HDR_VID, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) send_beat(fpix[i], 1'b0, (with_eop && i == n - 1));
    if (with_eop) begin
      for (int c = 0; c < NC; c++) begin
        cnt = 0;
        m_xmin[c] = 0; m_xmax[c] = 0; m_ymin[c] = 0; m_ymax[c] = 0;
        for (int i = 0; i < n; i++) begin
          if (i / W < H && m_match(c, fpix[i])) begin
            x = i % W; y = i / W;
            if (cnt == 0) begin
              m_xmin[c] = x; m_xmax[c] = x; m_ymin[c] = y; m_ymax[c] = y;
            end else begin
              if (x < m_xmin[c]) m_xmin[c] = x;
              if (x > m_xmax[c]) m_xmax[c] = x;
              if (y < m_ymin[c]) m_ymin[c] = y;
              if (y > m_ymax[c]) m_ymax[c] = y;
            end
            cnt++;
          end
        end
        m_valid[c] = (cnt >= MC);
      end
    end
  endtask

  // Non-video or header-only packet: everything forwarded unchanged.
  task automatic send_pkt(input logic [23:0] hdr, input int n);
    exp_q.push_back({1'b1, (n == 0), hdr});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), fpix[i]});
    send_beat(hdr, 1'b1, (n == 0));
    for (int i = 0; i < n; i++) send_beat(fpix[i], 1'b0, (i == n - 1));
  endtask

  task automatic reg_wr(input int c, input int f, input logic [31:0] v);
    @(posedge clk); #1;
    s_address = 4'(c * 4 + f); s_writedata = v; s_write = 1'b1;
    @(posedge clk); #1;
    s_write = 1'b0;
    if (f == 0) m_min[c] = v[23:0];
    else if (f == 1) m_max[c] = v[23:0];
  endtask

  task automatic rd_chk(input string tag, input int c, input int f, input logic [31:0] exp);
    @(posedge clk); #1;
    s_address = 4'(c * 4 + f); s_read = 1'b1;
    @(posedge clk); #1;
    s_read = 1'b0;
    check(tag, s_readdata, exp);
  endtask

  task automatic block_all();
    for (int c = 0; c < NC; c++) begin
      reg_wr(c, 0, 32'h00FFFFFF);
      reg_wr(c, 1, 32'h00000000);
    end
  endtask

  task automatic zero_frame();
    for (int i = 0; i < 64; i++) fpix[i] = 24'h000000;
  endtask

  // Output monitor: each accepted beat must be the next predicted one.
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {6'b0, source_sop, source_eop, source_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {6'b0, source_sop, source_eop, source_data}, {6'b0, e});
        end
      end
    end
  end

  // Downstream ready pattern
  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp)
        1:       source_ready = ~source_ready;
        2:       source_ready = 1'($urandom_range(0, 1));
        default: source_ready = 1'b1;
      endcase
    end
  end

  initial begin
    logic [23:0] p;
    int c, lo, hi, n, t;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, source_valid}, 32'd0);
    check("rst_data", {8'b0, source_data}, 32'd0);
    check("rst_sopeop", {30'b0, source_sop, source_eop}, 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    reset = 1'b0;
    rd_chk("rst_thr", 0, 0, 32'd0);
    rd_chk("rst_box", 1, 2, 32'd0);

    block_all();
    send_beat(24'h123456, 1'b0, 1'b0);   // stray beat in IDLE, dropped

    // Two red pixels
    reg_wr(0, 0, 32'h00C80000);
    reg_wr(0, 1, 32'h00FF3232);
    zero_frame();
    fpix[1*W+2] = 24'hFF0000;
    fpix[3*W+5] = 24'hFF0000;
    send_frame(32, 2'd0, 1'b1);
    rd_chk("A_bx", 0, 2, 32'h80050002);
    rd_chk("A_by", 0, 3, 32'h80030001);

    // Single red pixel: bounds latched, not valid
    zero_frame();
    fpix[3*W+3] = 24'hFF0000;
    send_frame(32, 2'd0, 1'b1);
    rd_chk("B_bx", 0, 2, 32'h00030003);
    rd_chk("B_by", 0, 3, 32'h00030003);

    // Non-video packet and a header-only video packet leave boxes alone
    for (int i = 0; i < 5; i++) fpix[i] = 24'($urandom);
    send_pkt(24'h00000F, 5);
    send_pkt(24'h000010, 0);
    rd_chk("other_bx", 0, 2, 32'h00030003);

    // Mask overlay, overlapping classes 0 and 1
    reg_wr(0, 0, 32'h00707070); reg_wr(0, 1, 32'h00909090);
    reg_wr(1, 0, 32'h00404040); reg_wr(1, 1, 32'h00C0C0C0);
    for (int i = 0; i < 32; i++)
      fpix[i] = (i % 3 == 0) ? 24'h808080 : ((i % 3 == 1) ? 24'hA0A0A0 : 24'h000000);
    send_frame(32, 2'd1, 1'b1);

    // Blue box (1,1)-(4,2) then box overlay
    block_all();
    reg_wr(2, 0, 32'h000000FF); reg_wr(2, 1, 32'h000000FF);
    zero_frame();
    fpix[1*W+1] = 24'h0000FF;
    fpix[2*W+4] = 24'h0000FF;
    send_frame(32, 2'd0, 1'b1);
    rd_chk("C_bx", 2, 2, 32'h80040001);
    rd_chk("C_by", 2, 3, 32'h80020001);
    for (int i = 0; i < 32; i++) fpix[i] = 24'h123456;
    send_frame(32, 2'd2, 1'b1);

    // Toggling backpressure
    bp = 1;
    for (int i = 0; i < 32; i++) fpix[i] = 24'($urandom);
    send_frame(32, 2'd0, 1'b1);
    bp = 0;

    // Reset after 10 pixels of a frame
    reg_wr(0, 0, 32'h00C80000); reg_wr(0, 1, 32'h00FF3232);
    zero_frame();
    fpix[0] = 24'hFF0000;
    fpix[9] = 24'hFF0000;
    send_frame(10, 2'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, source_valid}, 32'd0);
    reset = 1'b0;
    m_reset();
    rd_chk("midrst_box", 0, 2, 32'd0);
    block_all();
    reg_wr(0, 0, 32'h00C80000); reg_wr(0, 1, 32'h00FF3232);
    zero_frame();
    fpix[2*W+6] = 24'hFF0000;
    fpix[3*W+7] = 24'hFF0000;
    send_frame(32, 2'd0, 1'b1);
    rd_chk("D_bx", 0, 2, 32'h80070006);
    rd_chk("D_by", 0, 3, 32'h80030002);

    // Early eop after 12 pixels, then a full frame
    zero_frame();
    fpix[1]  = 24'hFF0000;
    fpix[11] = 24'hFF0000;
    send_frame(12, 2'd0, 1'b1);
    rd_chk("E_bx", 0, 2, 32'h80030001);
    rd_chk("E_by", 0, 3, 32'h80010000);
    zero_frame();
    fpix[0]  = 24'hFF0000;
    fpix[31] = 24'hFF0000;
    send_frame(32, 2'd0, 1'b1);
    rd_chk("F_bx", 0, 2, 32'h80070000);
    rd_chk("F_by", 0, 3, 32'h80030000);

    // Read and write of the same register in one cycle
    @(posedge clk); #1;
    s_address = 4'(3 * 4 + 0); s_writedata = 32'h00ABCDEF; s_write = 1'b1; s_read = 1'b1;
    @(posedge clk); #1;
    s_write = 1'b0; s_read = 1'b0;
    check("rw_old", s_readdata, m_reg(3, 0));
    m_min[3] = 24'hABCDEF;
    rd_chk("rw_new", 3, 0, 32'h00ABCDEF);

    // Randomised frames
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NC; k++) begin
        p = '0;
        for (int ch = 0; ch < 3; ch++) p[8*ch +: 8] = 8'($urandom_range(0, 200));
        reg_wr(k, 0, {8'h00, p});
        for (int ch = 0; ch < 3; ch++) begin
          hi = int'(p[8*ch +: 8]) + int'($urandom_range(0, 80));
          p[8*ch +: 8] = 8'((hi > 255) ? 255 : hi);
        end
        reg_wr(k, 1, {8'h00, p});
      end
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          fpix[i] = 24'($urandom);
        end else begin
          c = $urandom_range(0, NC - 1);
          for (int ch = 0; ch < 3; ch++) begin
            lo = int'(m_min[c][8*ch +: 8]);
            hi = int'(m_max[c][8*ch +: 8]);
            fpix[i][8*ch +: 8] = 8'($urandom_range(hi, lo));
          end
        end
      end
      bp = $urandom_range(0, 2);
      send_frame(n, 2'($urandom_range(0, 3)), 1'b1);
      if (it % 3 == 1) send_pkt(24'h00000F, 3);
      bp = 0;
      for (int k = 0; k < NC; k++) begin
        rd_chk("rnd_bx", k, 2, m_reg(k, 2));
        rd_chk("rnd_by", k, 3, m_reg(k, 3));
      end
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/colour_bbox_detector.md
Name: colour_bbox_detector

Overview:
- Parametrised successor to the single-mode eee_imgproc stage on the camera-to-VIP video path.
- Sits inline on the Avalon-ST video stream between the camera capture and the frame buffer/ITC.
- Classifies each pixel against NUM_COLOURS programmable RGB windows and accumulates a per-colour bounding box per frame.
- Publishes the boxes to Nios over Avalon-MM and can overlay a mask or boxes on the outgoing video.

Parameters:
- NUM_COLOURS, 4: number of colour classes; power of 2, 1..8.
- IMAGE_W, 640: active pixels per line.
- IMAGE_H, 480: active lines per frame.
- MIN_COUNT, 16: minimum matched pixels per frame for a box to be flagged valid.

Ports:
- clk in 1: single clock for all logic.
- reset in 1: synchronous, active-high.
- sink_data in 24: RGB pixel, R[23:16] G[15:8] B[7:0].
- sink_valid in 1; sink_ready out 1; sink_sop in 1; sink_eop in 1.
- source_data out 24; source_valid out 1; source_ready in 1; source_sop out 1; source_eop out 1.
- mode in 2: 0 passthrough, 1 mask overlay, 2 box overlay, 3 same as 0.
- s_address in clog2(NUM_COLOURS)+2: {colour, field}.
- s_read in 1; s_write in 1; s_writedata in 32.
- s_readdata out 32: register read data, read latency 1.

Behaviour:
- Reset values: source_valid=0, source_sop/eop=0, source_data=0, s_readdata=0, all thresholds 0, all boxes invalid (0), FSM=IDLE.
- Reset mid-frame drops the partial frame and clears all accumulators; nothing is passed until the next sop.
- Stream handshake:
  - One output register.
  - sink_ready = source_ready | ~source_valid.
  - A beat transfers when sink_valid & sink_ready; it appears on source one cycle later.
  - source_valid holds, and data/sop/eop stay stable, while source_ready=0.
- FSM:
  - IDLE: beats without sop are discarded (consumed, not forwarded). On a sop beat: data[3:0]==0 -> VIDEO; otherwise -> OTHER. The sop beat is forwarded unchanged.
  - VIDEO: pixel beats are counted and classified. On eop: latch boxes, clear accumulators, -> IDLE.
  - OTHER: all beats are forwarded unchanged. On eop -> IDLE.
  - sop and eop on the same beat: header-only packet; forward it, -> IDLE, no latch.
- Coordinates:
  - x and y reset to 0 on entering VIDEO.
  - x increments per pixel; at IMAGE_W-1, x wraps to 0 and y increments.
  - y saturates at IMAGE_H; pixels with y>=IMAGE_H are forwarded but excluded from stats.
- Match rule for colour c: each channel satisfies min_c <= ch <= max_c (inclusive, unsigned 8-bit). A pixel may match several colours.
- Per-colour accumulator:
  - Tracks xmin, xmax, ymin, ymax (11 bits each) and count (saturating, 20 bits).
  - First match sets all four bounds; later matches update them with min/max.
- Latch on VIDEO eop: box_c.valid = (count >= MIN_COUNT). The bounds are latched regardless of validity. Short frames (early eop) latch normally.
- Overlay, VIDEO pixel beats only:
  - mode 1: matching pixel replaced by palette[lowest matching index]. Palette: 0 red FF0000, 1 green 00FF00, 2 blue 0000FF, 3 yellow FFFF00, 4+ white.
  - mode 2: pixel lying on the perimeter of any valid latched box (x==xmin|x==xmax with y in range, or y==ymin|y==ymax with x in range) replaced by FFFFFF.
  - mode is sampled per beat.
- Register map per colour c:
  - field 0, RW: min {8'h0,R,G,B}.
  - field 1, RW: max, same layout.
  - field 2, RO: {valid, 4'b0, xmax[10:0], 5'b0, xmin[10:0]}.
  - field 3, RO: {valid, 4'b0, ymax[10:0], 5'b0, ymin[10:0]}.
- Register access rules:
  - Writes to RO fields are ignored.
  - A write takes effect on the next pixel.
  - A read in the same cycle as an eop latch returns the pre-latch value.
  - s_read and s_write in the same cycle: the write is performed and readdata returns the old value.

Decomposition:
- Shared package colour_bbox_pkg:
  - field offsets FLD_MIN/FLD_MAX/FLD_BX/FLD_BY;
  - VIP_PKT_VIDEO=4'h0;
  - mode encodings;
  - palette constant;
  - COORD_W=11 and CNT_W=20.
- One sub-module colour_bbox_acc: match comparator, accumulator and latched box for one colour; generated NUM_COLOURS times.
- The top level holds the FSM, coordinate counters, output register, overlay mux and Avalon-MM decode.

Test Plan:
- Bench parameters: IMAGE_W=8, IMAGE_H=4, MIN_COUNT=2.
- Colour 0 window R 200..255, G/B 0..50; pixels FF0000 at (2,1),(5,3), rest 000000 -> field 2 reads 8000_0005|xmin 2, field 3 ymin 1 ymax 3, valid=1.
- Single matching pixel at (3,3) -> valid=0, bounds 3/3 latched. Non-video packet (header type 4'hF) -> forwarded bit-exact, boxes unchanged.
- Backpressure: source_ready toggles 0/1 every cycle across a 32-pixel frame -> output sequence identical to input, no drops/duplicates, sop/eop preserved.
- mode=1 with colours 0 and 1 both matching pixel 808080 -> output FF0000. mode=2 with latched box (1,1)-(4,2) -> pixels (1..4,1),(1..4,2),(1,*),(4,*) in range become FFFFFF.
- Assert reset at pixel 10 of a frame, then a full frame -> the partial frame produces no latch; the next eop latches only the new frame's box; source_valid=0 on the cycle after reset.
- Early eop after 12 pixels (y=1,x=3) with matches -> latch occurs, x/y restart at 0 on next video sop.
